// File: rtl/data_table_ram.sv
// Data table RAM for the hash table. It has a fixed-latency read port, a write-first write port,
// and a sequential clear engine that zeroes the whole table.
package data_table_pkg;
  localparam int TABLE_ADDR_WIDTH = 10;
  typedef logic [63:0] ram_data_t;
endpackage

module data_table_ram
  import data_table_pkg::*;
#(
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int D_WIDTH     = $bits(ram_data_t),
  parameter int RAM_LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rd_en_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_data_val_o,
  input  logic               wr_en_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [D_WIDTH-1:0] wr_data_i,
  output logic               wr_ready_o,
  input  logic               clear_i,
  output logic               clear_busy_o,
  output logic               clear_done_o
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [A_WIDTH:0] CNT_LAST = (A_WIDTH + 1)'(DEPTH - 1);

  logic [0:0]         state_q, state_d;
  logic [A_WIDTH:0]   cnt_q, cnt_d;
  logic [D_WIDTH-1:0] mem [DEPTH];

  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] rd_word;

  logic [RAM_LATENCY-1:0] pipe_val_q, pipe_val_d;
  logic [D_WIDTH-1:0]     pipe_data_q [RAM_LATENCY];
  logic [D_WIDTH-1:0]     pipe_data_d [RAM_LATENCY];

  // Clear FSM: walks the counter from 0 to DEPTH-1. A clear_i that arrives mid-clear is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + (A_WIDTH + 1)'(1);
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_ready_o   = (state_q == ST_IDLE);
  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = (state_q == ST_CLEAR) && (cnt_q == CNT_LAST);

  // The clear engine owns the write port while it runs. External writes during a clear are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[A_WIDTH-1:0];
      mem_wdata = '0;
    end else if (wr_en_i) begin
      mem_we = 1'b1;
    end
    rd_word = (mem_we && (mem_waddr == rd_addr_i)) ? mem_wdata : mem[rd_addr_i];
  end

  // A data stage loads only behind a valid. The last stage therefore holds its value between reads.
  always_comb begin
    pipe_val_d[0]  = rd_en_i;
    pipe_data_d[0] = rd_en_i ? rd_word : pipe_data_q[0];
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_val_d[i]  = pipe_val_q[i-1];
      pipe_data_d[i] = pipe_val_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
    end
  end

  assign rd_data_o     = pipe_data_q[RAM_LATENCY-1];
  assign rd_data_val_o = pipe_val_q[RAM_LATENCY-1];

  // NOTE: the storage array has no reset on purpose. Resetting every word would block RAM inference.
  // The clear engine is the way to zero the table.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pipe_val_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_val_q <= pipe_val_d;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_data_q[i] <= pipe_data_d[i];
    end
  end

endmodule
